// File: rtl/counter_pkg.sv
// Constants shared by the counter family (up, down and future variants).
package counter_pkg;

    localparam int COUNTER_WIDTH = 4;

endpackage

// File: rtl/tff_sync.sv
// Single-bit toggle flip-flop with synchronous reset and parallel load.
module tff_sync (
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q
);

    logic bit_d;
    logic bit_q;

    always_comb begin
        bit_d = bit_q;
        if (ld) begin
            bit_d = d;
        end else if (t) begin
            bit_d = ~bit_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign q = bit_q;

endmodule

// File: rtl/up_counter.sv
// Loadable modulo-(lim+1) up counter built from toggle flops, with a
// combinational terminal count for cascading and a sticky wrap flag.
module up_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] lim,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] toggle;
    logic             wrap;
    logic             ovf_d;
    logic             ovf_q;

    // A wrap happens on exactly the edges where tc is high.
    assign wrap = en & ~ld & (cnt >= lim);
    assign tc   = wrap;

    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_carry
            assign carry[gi] = carry[gi-1] & cnt[gi-1];
        end

        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            // On a wrap every set bit toggles, clearing the whole count.
            assign toggle[gi] = wrap ? cnt[gi] : (en & carry[gi]);

            tff_sync u_tff (
                .clk (clk),
                .rst (rst),
                .t   (toggle[gi]),
                .ld  (ld),
                .d   (d[gi]),
                .q   (cnt[gi])
            );
        end
    endgenerate

    always_comb begin
        ovf_d = ovf_q;
        if (wrap) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign q   = cnt;
    assign ovf = ovf_q;

endmodule
